// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over a REQ/ACK handshake
// and holds one fetched instruction plus its PC in a valid/ready output register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] pc;
    logic [31:0] reqAddr;
    logic        outFree;
    logic        loadOut;
    logic        captureAddr;

    assign outFree = !instr_valid || instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // A request, once raised, stays up at the same address until ACK; a
    // redirect while waiting parks the FSM in DROP so that data is thrown away.
    always_comb begin
        stateNext   = state;
        imem_req    = 1'b0;
        imem_addr   = 32'h0;
        loadOut     = 1'b0;
        captureAddr = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_req  = outFree;
                    imem_addr = pc;
                    if (imem_req && !imem_ack) begin
                        captureAddr = 1'b1;
                        stateNext   = redirect ? DROP : WAIT;
                    end else if (imem_req && !redirect) begin
                        loadOut = 1'b1;
                    end
                end
                WAIT: begin
                    imem_req  = 1'b1;
                    imem_addr = reqAddr;
                    if (imem_ack) begin
                        stateNext = FETCH;
                        loadOut   = !redirect;
                    end else if (redirect) begin
                        stateNext = DROP;
                    end
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = reqAddr;
                    if (imem_ack) begin
                        stateNext = FETCH;
                    end
                end
                default: begin
                    stateNext = FETCH;
                end
            endcase
        end
    end

    // Redirect wins over a load or a transfer: it flushes the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            reqAddr     <= 32'h0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            if (captureAddr) begin
                reqAddr <= pc;
            end
            if (redirect) begin
                pc          <= redirect_pc & ~32'h3;
                instr_valid <= 1'b0;
            end else if (loadOut) begin
                instr       <= imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + STEP;
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a memory responder drives ACKs,
// a stream model predicts delivered instructions, and a monitor checks transfers.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch #(.RESET_PC(32'h00000000), .PC_STEP(4)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: the architectural stream PC and the memory request.
    logic [31:0] refPc;
    logic [63:0] expQ[$];
    bit          outstanding;
    bit          stale;
    logic [31:0] memAddr;
    int          waitLeft;
    int          latMode;
    bit          lastPushed;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive inputs, act as memory, update the model.
    task automatic applyStimulus(input bit doRedir, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        if (lastPushed) checkOutput("valid_after_ack", {31'h0, instr_valid}, 32'h1);
        lastPushed  = 0;
        redirect    = doRedir;
        redirect_pc = rpc;
        instr_ready = doRedir ? 1'b0 : rdy;
        imem_ack    = 1'b0;
        imem_data   = 32'h0;
        #1;
        if (outstanding) begin
            checkOutput("req_held", {31'h0, imem_req}, 32'h1);
            checkOutput("addr_stable", imem_addr, memAddr);
        end else begin
            checkOutput("req_gate", {31'h0, imem_req}, {31'h0, (!instr_valid || instr_ready)});
            if (imem_req) begin
                outstanding = 1;
                stale       = 0;
                memAddr     = imem_addr;
                waitLeft    = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
                checkOutput("req_addr", imem_addr, refPc);
            end
        end
        if (imem_req) checkOutput("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
        if (outstanding) begin
            if (waitLeft == 0) begin
                imem_ack    = 1'b1;
                imem_data   = memWord(memAddr);
                outstanding = 0;
                if (!doRedir && !stale) begin
                    expQ.push_back({memAddr, memWord(memAddr)});
                    refPc      = refPc + 32'd4;
                    lastPushed = 1;
                end
            end else begin
                waitLeft--;
            end
        end
        if (doRedir) begin
            if (outstanding) stale = 1;
            refPc = rpc & ~32'h3;
            expQ.delete();
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        #1;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        #1;
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        refPc       = 32'h0;
        outstanding = 0;
        stale       = 0;
        lastPushed  = 0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one expected instruction for every observed transfer.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_valid && instr_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_instr_pc", instr_pc, 32'hDEADDEAD);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("instr_pc", instr_pc, e[63:32]);
                    checkOutput("instr", instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        bit found;
        logic [31:0] rpc;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        refPc       = 32'h0;
        outstanding = 0;
        stale       = 0;
        lastPushed  = 0;
        latMode     = 0;
        #1;
        checkOutput("por_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("por_req", {31'h0, imem_req}, 32'h0);
        checkOutput("por_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        latMode = 0;
        repeat (8) applyStimulus(0, 32'h0, 1);

        latMode = 2;
        repeat (12) applyStimulus(0, 32'h0, 1);

        latMode = 0;
        repeat (5) applyStimulus(0, 32'h0, 0);
        repeat (6) applyStimulus(0, 32'h0, 1);

        resetDut();
        latMode = 2;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(0, 32'h0, 1);
            if (outstanding && memAddr == 32'h8 && waitLeft > 0) found = 1;
        end
        if (!found) checkOutput("wait_for_req8", 32'h0, 32'h8);
        applyStimulus(1, 32'h103, 1);
        repeat (12) applyStimulus(0, 32'h0, 1);

        latMode = 0;
        applyStimulus(1, 32'hFFFFFFF5, 1);
        repeat (6) applyStimulus(0, 32'h0, 1);

        latMode = 3;
        applyStimulus(0, 32'h0, 1);
        resetDut();
        latMode = 0;
        repeat (3) applyStimulus(0, 32'h0, 0);
        resetDut();
        repeat (4) applyStimulus(0, 32'h0, 1);

        latMode = -1;
        for (int i = 0; i < 2000; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        latMode = 0;
        repeat (4) applyStimulus(0, 32'h0, 1);
        #2;
        checkOutput("scoreboard_backlog", {31'h0, expQ.size() > 1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
